// File: rtl/rail_rush_pkg.sv
// Shared types and lane helpers for the spawn scheduler.
package rail_rush_pkg;

    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned CNT_W     = 6;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_GRANT = 2'd2
    } sched_state_t;

    // Lane code 3 does not exist on the track and folds onto lane 0.
    function automatic lane_t norm_lane(input lane_t lane);
        return (lane == LANE_W'(3)) ? LANE_W'(0) : lane;
    endfunction

    function automatic lane_t next_lane(input lane_t lane);
        return (lane >= LANE_W'(2)) ? LANE_W'(0) : LANE_W'(lane + LANE_W'(1));
    endfunction

endpackage

// File: rtl/spawn_scheduler_lane_cooldown.sv
// Per-lane obstacle and coin cooldown counters with registered blocked flags.
module lane_cooldown
    import rail_rush_pkg::*;
#(
    parameter int unsigned OBS_COOLDOWN  = 40,
    parameter int unsigned COIN_COOLDOWN = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic dec,
    input  logic clr,
    input  logic obs_load,
    input  logic coin_load,
    output logic obs_blocked,
    output logic coin_blocked
);

    cnt_t obs_cd_q, obs_cd_d;
    cnt_t coin_cd_q, coin_cd_d;
    logic obs_blocked_q, obs_blocked_d;
    logic coin_blocked_q, coin_blocked_d;

    // Clear beats load beats the saturating frame decrement.
    always_comb begin
        obs_cd_d  = obs_cd_q;
        coin_cd_d = coin_cd_q;
        if (clr) begin
            obs_cd_d  = '0;
            coin_cd_d = '0;
        end else begin
            if (obs_load) begin
                obs_cd_d = CNT_W'(OBS_COOLDOWN);
            end else if (dec && obs_cd_q != '0) begin
                obs_cd_d = obs_cd_q - CNT_W'(1);
            end
            if (coin_load) begin
                coin_cd_d = CNT_W'(COIN_COOLDOWN);
            end else if (dec && coin_cd_q != '0) begin
                coin_cd_d = coin_cd_q - CNT_W'(1);
            end
        end
        obs_blocked_d  = (obs_cd_d != '0);
        coin_blocked_d = (coin_cd_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            obs_cd_q       <= '0;
            coin_cd_q      <= '0;
            obs_blocked_q  <= 1'b0;
            coin_blocked_q <= 1'b0;
        end else begin
            obs_cd_q       <= obs_cd_d;
            coin_cd_q      <= coin_cd_d;
            obs_blocked_q  <= obs_blocked_d;
            coin_blocked_q <= coin_blocked_d;
        end
    end

    assign obs_blocked  = obs_blocked_q;
    assign coin_blocked = coin_blocked_q;

endmodule

// File: rtl/spawn_scheduler.sv
// Per-frame spawn arbiter: one grant per frame between the obstacle and coin pools.
module spawn_scheduler
    import rail_rush_pkg::*;
#(
    parameter int unsigned OBS_COOLDOWN  = 40,
    parameter int unsigned COIN_COOLDOWN = 20,
    parameter int unsigned MIN_GAP       = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_done,
    input  logic              game_active,
    input  logic              obs_req,
    input  logic [LANE_W-1:0] obs_lane,
    input  logic              coin_req,
    input  logic [LANE_W-1:0] coin_lane,
    output logic              obs_grant,
    output logic              coin_grant,
    output logic [LANE_W-1:0] grant_lane,
    output logic [NUM_LANES-1:0] lanes_blocked
);

    sched_state_t state_q, state_d;

    cnt_t  gap_cnt_q, gap_cnt_d;
    logic  last_was_obs_q, last_was_obs_d;
    logic  obs_grant_q, obs_grant_d;
    logic  coin_grant_q, coin_grant_d;
    lane_t grant_lane_q, grant_lane_d;

    logic                 cd_dec, cd_clr;
    logic [NUM_LANES-1:0] obs_load, coin_load;
    logic [NUM_LANES-1:0] obs_blocked, coin_blocked;

    lane_t      obs_l, coin_pick, coin_cand;
    logic [1:0] others_blocked;
    logic       obs_ok, coin_ok, coin_found;
    logic       grant_obs, grant_coin;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_cooldown #(
            .OBS_COOLDOWN (OBS_COOLDOWN),
            .COIN_COOLDOWN(COIN_COOLDOWN)
        ) u_cd (
            .clock       (clock),
            .reset       (reset),
            .dec         (cd_dec),
            .clr         (cd_clr),
            .obs_load    (obs_load[i]),
            .coin_load   (coin_load[i]),
            .obs_blocked (obs_blocked[i]),
            .coin_blocked(coin_blocked[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!game_active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (frame_done) state_d = S_EVAL;
                S_EVAL:  state_d = S_GRANT;
                S_GRANT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Eligibility: obstacles keep one lane open; coins slide to the next free lane.
    always_comb begin
        obs_l          = norm_lane(obs_lane);
        others_blocked = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (LANE_W'(i) != obs_l && obs_blocked[LANE_W'(i)]) begin
                others_blocked = others_blocked + 2'd1;
            end
        end
        obs_ok = obs_req && (gap_cnt_q == '0) && !obs_blocked[obs_l]
                 && (others_blocked < 2'd2);

        coin_found = 1'b0;
        coin_cand  = norm_lane(coin_lane);
        coin_pick  = coin_cand;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (!coin_found && !obs_blocked[coin_cand] && !coin_blocked[coin_cand]) begin
                coin_found = 1'b1;
                coin_pick  = coin_cand;
            end
            coin_cand = next_lane(coin_cand);
        end
        coin_ok = coin_req && (gap_cnt_q == '0) && coin_found;

        grant_obs  = obs_ok && (!coin_ok || !last_was_obs_q);
        grant_coin = coin_ok && !grant_obs;
    end

    always_comb begin
        obs_grant_d    = 1'b0;
        coin_grant_d   = 1'b0;
        grant_lane_d   = '0;
        gap_cnt_d      = gap_cnt_q;
        last_was_obs_d = last_was_obs_q;
        cd_dec         = 1'b0;
        cd_clr         = 1'b0;
        obs_load       = '0;
        coin_load      = '0;
        if (!game_active) begin
            cd_clr    = 1'b1;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_done) begin
                        cd_dec = 1'b1;
                        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    if (grant_obs) begin
                        obs_grant_d     = 1'b1;
                        grant_lane_d    = obs_l;
                        obs_load[obs_l] = 1'b1;
                        gap_cnt_d       = CNT_W'(MIN_GAP);
                        last_was_obs_d  = 1'b1;
                    end else if (grant_coin) begin
                        coin_grant_d         = 1'b1;
                        grant_lane_d         = coin_pick;
                        coin_load[coin_pick] = 1'b1;
                        gap_cnt_d            = CNT_W'(MIN_GAP);
                        last_was_obs_d       = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt_q      <= '0;
            last_was_obs_q <= 1'b0;
            obs_grant_q    <= 1'b0;
            coin_grant_q   <= 1'b0;
            grant_lane_q   <= '0;
        end else begin
            gap_cnt_q      <= gap_cnt_d;
            last_was_obs_q <= last_was_obs_d;
            obs_grant_q    <= obs_grant_d;
            coin_grant_q   <= coin_grant_d;
            grant_lane_q   <= grant_lane_d;
        end
    end

    assign obs_grant     = obs_grant_q;
    assign coin_grant    = coin_grant_q;
    assign grant_lane    = grant_lane_q;
    assign lanes_blocked = obs_blocked;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Randomized and directed bench for spawn_scheduler against a frame-level reference model.
module tb_spawn_scheduler;

    localparam int OBS_CD  = 40;
    localparam int COIN_CD = 20;
    localparam int GAP     = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_done;
    logic       game_active;
    logic       obs_req;
    logic [1:0] obs_lane;
    logic       coin_req;
    logic [1:0] coin_lane;
    logic       obs_grant;
    logic       coin_grant;
    logic [1:0] grant_lane;
    logic [2:0] lanes_blocked;

    spawn_scheduler #(
        .OBS_COOLDOWN (OBS_CD),
        .COIN_COOLDOWN(COIN_CD),
        .MIN_GAP      (GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_done   (frame_done),
        .game_active  (game_active),
        .obs_req      (obs_req),
        .obs_lane     (obs_lane),
        .coin_req     (coin_req),
        .coin_lane    (coin_lane),
        .obs_grant    (obs_grant),
        .coin_grant   (coin_grant),
        .grant_lane   (grant_lane),
        .lanes_blocked(lanes_blocked)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one step per accepted frame.
    int m_ocd[3];
    int m_ccd[3];
    int m_gap;
    bit m_last;
    bit e_og, e_cg;
    int e_lane;

    // Values seen in the last grant cycle, for directed checks.
    logic       g_og, g_cg;
    logic [1:0] g_lane;
    logic [2:0] g_blk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 3; i++) begin
            m_ocd[i] = 0;
            m_ccd[i] = 0;
        end
        m_gap = 0;
    endfunction

    function automatic logic [2:0] m_blocked();
        logic [2:0] b;
        for (int i = 0; i < 3; i++) b[i] = (m_ocd[i] != 0);
        return b;
    endfunction

    function automatic void m_frame();
        int  ol, cl, clane, others;
        bit  ook, cok;
        for (int i = 0; i < 3; i++) begin
            if (m_ocd[i] > 0) m_ocd[i]--;
            if (m_ccd[i] > 0) m_ccd[i]--;
        end
        if (m_gap > 0) m_gap--;
        e_og = 0; e_cg = 0; e_lane = 0;
        ol = (obs_lane == 2'd3) ? 0 : int'(obs_lane);
        others = 0;
        for (int j = 0; j < 3; j++) if (j != ol && m_ocd[j] != 0) others++;
        ook = obs_req && m_gap == 0 && m_ocd[ol] == 0 && others < 2;
        cl = (coin_lane == 2'd3) ? 0 : int'(coin_lane);
        cok = 0; clane = 0;
        for (int k = 0; k < 3; k++) begin
            int l;
            l = (cl + k) % 3;
            if (!cok && m_ocd[l] == 0 && m_ccd[l] == 0) begin
                cok = 1; clane = l;
            end
        end
        cok = cok && coin_req && m_gap == 0;
        if (ook && (!cok || !m_last)) begin
            e_og = 1; e_lane = ol; m_ocd[ol] = OBS_CD; m_last = 1; m_gap = GAP;
        end else if (cok) begin
            e_cg = 1; e_lane = clane; m_ccd[clane] = COIN_CD; m_last = 0; m_gap = GAP;
        end
    endfunction

    // Called at a negedge; returns at a negedge with the DUT back in idle.
    task automatic run_frame(input bit ea_drop, input bit extra_fd);
        bit keep_last;
        frame_done = 1'b1;
        @(negedge clock);
        frame_done = 1'b0;
        check_eq("eval_obs_grant", 32'(obs_grant), 32'(0));
        check_eq("eval_coin_grant", 32'(coin_grant), 32'(0));
        keep_last = m_last;
        m_frame();
        if (ea_drop) begin
            game_active = 1'b0;
            m_clear();
            m_last = keep_last;
            e_og = 0; e_cg = 0;
        end
        frame_done = extra_fd;
        @(negedge clock);
        frame_done  = 1'b0;
        game_active = 1'b1;
        g_og = obs_grant; g_cg = coin_grant; g_lane = grant_lane; g_blk = lanes_blocked;
        check_eq("grant_obs", 32'(obs_grant), 32'(e_og));
        check_eq("grant_coin", 32'(coin_grant), 32'(e_cg));
        if (e_og || e_cg) check_eq("grant_lane", 32'(grant_lane), 32'(e_lane));
        check_eq("lanes_blocked", 32'(lanes_blocked), 32'(m_blocked()));
        if (e_og) obs_req = 1'b0;
        if (e_cg) coin_req = 1'b0;
        @(negedge clock);
        check_eq("idle_obs_grant", 32'(obs_grant), 32'(0));
        check_eq("idle_coin_grant", 32'(coin_grant), 32'(0));
    endtask

    task automatic run_n(input int n, output int grants);
        grants = 0;
        for (int f = 0; f < n; f++) begin
            run_frame(1'b0, 1'b0);
            grants += int'(g_og) + int'(g_cg);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_done = 1'b0; game_active = 1'b1;
        obs_req = 1'b0; obs_lane = 2'd0; coin_req = 1'b0; coin_lane = 2'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_clear(); m_last = 0;
        check_eq("rst_obs_grant", 32'(obs_grant), 32'(0));
        check_eq("rst_coin_grant", 32'(coin_grant), 32'(0));
        check_eq("rst_grant_lane", 32'(grant_lane), 32'(0));
        check_eq("rst_lanes_blocked", 32'(lanes_blocked), 32'(0));
    endtask

    initial begin
        int n;
        do_reset();

        // Single obstacle with fixed latency, then a quiet gap.
        obs_req = 1'b1; obs_lane = 2'd1;
        run_frame(1'b0, 1'b0);
        check_eq("d1_og", 32'(g_og), 32'(1));
        check_eq("d1_lane", 32'(g_lane), 32'(1));
        check_eq("d1_blk", 32'(g_blk), 32'(3'b010));
        coin_req = 1'b1; coin_lane = 2'd0;
        run_n(11, n);
        check_eq("d1_gap_quiet", 32'(n), 32'(0));
        run_frame(1'b0, 1'b0);
        check_eq("d1_coin_after_gap", 32'(g_cg), 32'(1));

        // Alternation, then escape lane protection.
        do_reset();
        obs_req = 1'b1; obs_lane = 2'd0; coin_req = 1'b1; coin_lane = 2'd2;
        run_frame(1'b0, 1'b0);
        check_eq("d2_f1_og", 32'(g_og), 32'(1));
        check_eq("d2_f1_lane", 32'(g_lane), 32'(0));
        obs_req = 1'b1; obs_lane = 2'd1;
        run_n(11, n);
        check_eq("d2_quiet1", 32'(n), 32'(0));
        run_frame(1'b0, 1'b0);
        check_eq("d2_f13_cg", 32'(g_cg), 32'(1));
        check_eq("d2_f13_lane", 32'(g_lane), 32'(2));
        run_n(11, n);
        check_eq("d2_quiet2", 32'(n), 32'(0));
        run_frame(1'b0, 1'b0);
        check_eq("d2_f25_og", 32'(g_og), 32'(1));
        check_eq("d2_f25_lane", 32'(g_lane), 32'(1));
        obs_req = 1'b1; obs_lane = 2'd2;
        run_n(15, n);
        check_eq("d3_escape_hold", 32'(n), 32'(0));
        check_eq("d3_blk_f40", 32'(g_blk), 32'(3'b011));
        run_frame(1'b0, 1'b0);
        check_eq("d3_f41_og", 32'(g_og), 32'(1));
        check_eq("d3_f41_lane", 32'(g_lane), 32'(2));

        // Coin redirect around obstacle-blocked lanes.
        do_reset();
        obs_req = 1'b1; obs_lane = 2'd1;
        run_frame(1'b0, 1'b0);
        coin_req = 1'b1; coin_lane = 2'd1;
        run_n(11, n);
        run_frame(1'b0, 1'b0);
        check_eq("d4_redirect_cg", 32'(g_cg), 32'(1));
        check_eq("d4_redirect_lane", 32'(g_lane), 32'(2));
        obs_req = 1'b1; obs_lane = 2'd2;
        run_n(12, n);
        check_eq("d4_obs2", 32'(g_og), 32'(1));
        coin_req = 1'b1; coin_lane = 2'd1;
        run_n(11, n);
        run_frame(1'b0, 1'b0);
        check_eq("d4_wrap_cg", 32'(g_cg), 32'(1));
        check_eq("d4_wrap_lane", 32'(g_lane), 32'(0));

        // Lane code 3 folds to lane 0; game_active drop clears everything.
        do_reset();
        coin_req = 1'b1; coin_lane = 2'd3;
        run_frame(1'b0, 1'b0);
        check_eq("d5_lane3_cg", 32'(g_cg), 32'(1));
        check_eq("d5_lane3_lane", 32'(g_lane), 32'(0));
        obs_req = 1'b1; obs_lane = 2'd0;
        run_n(12, n);
        check_eq("d6_loaded_blk", 32'(g_blk), 32'(3'b001));
        game_active = 1'b0;
        @(negedge clock);
        game_active = 1'b1;
        m_clear();
        check_eq("d6_clr_blk", 32'(lanes_blocked), 32'(0));
        coin_req = 1'b1; coin_lane = 2'd3;
        run_frame(1'b0, 1'b0);
        check_eq("d6_after_clr_cg", 32'(g_cg), 32'(1));
        check_eq("d6_after_clr_lane", 32'(g_lane), 32'(0));

        // Reset landing in the evaluation cycle.
        obs_req = 1'b1; obs_lane = 2'd1;
        frame_done = 1'b1;
        @(negedge clock);
        frame_done = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_clear(); m_last = 0;
        check_eq("d7_rst_og", 32'(obs_grant), 32'(0));
        check_eq("d7_rst_cg", 32'(coin_grant), 32'(0));
        check_eq("d7_rst_blk", 32'(lanes_blocked), 32'(0));
        @(negedge clock);
        check_eq("d7_no_late_og", 32'(obs_grant), 32'(0));
        obs_lane = 2'd2;
        run_frame(1'b0, 1'b0);
        check_eq("d7_next_og", 32'(g_og), 32'(1));
        check_eq("d7_next_lane", 32'(g_lane), 32'(2));

        // Randomized traffic.
        do_reset();
        for (int f = 0; f < 600; f++) begin
            int idle;
            if (!obs_req && $urandom_range(0, 2) == 0) begin
                obs_req = 1'b1; obs_lane = 2'($urandom_range(0, 3));
            end
            if (!coin_req && $urandom_range(0, 2) == 0) begin
                coin_req = 1'b1; coin_lane = 2'($urandom_range(0, 3));
            end
            idle = $urandom_range(0, 2);
            for (int c = 0; c < idle; c++) @(negedge clock);
            if ($urandom_range(0, 49) == 0) begin
                game_active = 1'b0;
                @(negedge clock);
                game_active = 1'b1;
                m_clear();
                check_eq("rnd_clr_blk", 32'(lanes_blocked), 32'(0));
            end
            run_frame($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
